// File: rtl/gxgy_pkg.sv
// Shared types and dimensions for the Gx/Gy AXI4-Stream output stage.
package gxgy_pkg;

    localparam int unsigned IMG_DIM_W   = 13;
    localparam int unsigned BEAT_DATA_W = 32;

    // One buffered output beat: framing tags plus the Gx/Gy vector.
    typedef struct packed {
        logic                   tuser;
        logic                   tlast;
        logic [BEAT_DATA_W-1:0] data;
    } gxgy_beat_t;

    // Write-side framing state.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } wr_state_e;

endpackage

// File: rtl/gxgy_sync_fifo.sv
// Single-clock show-ahead FIFO; a write while full is accepted when a read frees the slot.
module gxgy_sync_fifo
    import gxgy_pkg::*;
#(
    parameter int unsigned DATA_W = 34,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              wr_ok_c;
    logic              rd_ok_c;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign rd_ok_c = rd_en && !empty;
    assign wr_ok_c = wr_en && (!full || rd_ok_c);

    // Storage array; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({wr_ok_c, rd_ok_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gxgy_axis_frame_tx.sv
// Buffers the Gx/Gy pixel stream and re-frames it as AXI4-Stream video (tuser=SOF, tlast=EOL).
module gxgy_axis_frame_tx
    import gxgy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned AF_MARGIN   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic [IMG_DIM_W-1:0]  WIDTH,
    input  logic [IMG_DIM_W-1:0]  HEIGHT,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    input  logic                  i_pixel_valid,
    input  logic                  i_start_of_frame,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    output logic                  o_frame_err,
    input  logic                  i_clear_status
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IMG_DIM_W-1:0] KSIZE    = IMG_DIM_W'(KERNEL_SIZE);
    localparam logic [IMG_DIM_W-1:0] CROP     = IMG_DIM_W'(KERNEL_SIZE - 1);
    localparam logic [IMG_DIM_W-1:0] ONE      = IMG_DIM_W'(1);
    localparam logic [CNT_W-1:0]     AF_LEVEL = CNT_W'(FIFO_DEPTH - AF_MARGIN);

    wr_state_e            state_q, state_d;
    logic [IMG_DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [IMG_DIM_W-1:0] out_w_q, out_w_d, out_h_q, out_h_d;
    logic [IMG_DIM_W-1:0] cur_col_c, cur_row_c, cur_w_c, cur_h_c;
    logic                 frame_err_d;
    logic                 tag_vld_c, tag_user_c, tag_last_c;
    logic                 sof_c, geom_ok_c;

    logic                 fifo_wr_c, fifo_rd_c, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_din, fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 ovf_event_c;

    assign sof_c     = i_pixel_valid && i_start_of_frame;
    assign geom_ok_c = (WIDTH >= KSIZE) && (HEIGHT >= KSIZE);

    // Write-side FSM state register.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tagging, counter advance and next state; SOF pixels use the live geometry.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_w_d     = out_w_q;
        out_h_d     = out_h_q;
        frame_err_d = 1'b0;
        tag_vld_c   = 1'b0;
        tag_user_c  = 1'b0;
        tag_last_c  = 1'b0;
        cur_col_c   = col_q;
        cur_row_c   = row_q;
        cur_w_c     = out_w_q;
        cur_h_c     = out_h_q;

        if (sof_c) begin
            cur_col_c = '0;
            cur_row_c = '0;
            cur_w_c   = WIDTH - CROP;
            cur_h_c   = HEIGHT - CROP;
            if (!geom_ok_c || (state_q == ST_IN_FRAME)) begin
                frame_err_d = 1'b1;
            end
            if (geom_ok_c) begin
                out_w_d   = cur_w_c;
                out_h_d   = cur_h_c;
                tag_vld_c = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (i_pixel_valid && (state_q == ST_IN_FRAME)) begin
            tag_vld_c = 1'b1;
        end

        if (tag_vld_c) begin
            tag_user_c = (cur_col_c == '0) && (cur_row_c == '0);
            tag_last_c = (cur_col_c == cur_w_c - ONE);
            if (tag_last_c) begin
                col_d = '0;
                if (cur_row_c == cur_h_c - ONE) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d   = cur_row_c + ONE;
                    state_d = ST_IN_FRAME;
                end
            end else begin
                col_d   = cur_col_c + ONE;
                row_d   = cur_row_c;
                state_d = ST_IN_FRAME;
            end
        end
    end

    // Frame-geometry counters and the frame-error pulse.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            col_q       <= '0;
            row_q       <= '0;
            out_w_q     <= '0;
            out_h_q     <= '0;
            o_frame_err <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_w_q     <= out_w_d;
            out_h_q     <= out_h_d;
            o_frame_err <= frame_err_d;
        end
    end

    // Counters advance even when a pixel is dropped, so framing stays aligned.
    assign fifo_rd_c   = !fifo_empty && (!m_axis_tvalid || m_axis_tready);
    assign fifo_wr_c   = tag_vld_c && (!fifo_full || fifo_rd_c);
    assign ovf_event_c = tag_vld_c && fifo_full && !fifo_rd_c;
    assign fifo_din    = {tag_user_c, tag_last_c, i_pixel};

    gxgy_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .wr_en     (fifo_wr_c),
        .din       (fifo_din),
        .rd_en     (fifo_rd_c),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_almost_full = (fifo_count >= AF_LEVEL);

    // AXI4-Stream output register; payload holds while stalled.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (fifo_rd_c) begin
            m_axis_tvalid <= 1'b1;
            {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= fifo_dout;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_overflow <= 1'b0;
        end else if (ovf_event_c) begin
            o_overflow <= 1'b1;
        end else if (i_clear_status) begin
            o_overflow <= 1'b0;
        end
    end

endmodule

// File: doc/gxgy_axis_frame_tx.md
Name: gxgy_axis_frame_tx

Overview:
- Output end of the gradient pipeline. Accepts the 32-bit Gx/Gy vector stream from the processing stage as pixel + valid + start-of-frame. That stream has no backpressure.
- Buffers the stream in a small FIFO and regenerates AXI4-Stream video framing (tuser = SOF, tlast = EOL) from frame-geometry counters.
- Drives the AXI4-Stream master with full m_axis_tready support and flags overflow and framing errors.

Parameters:
- DATA_WIDTH, 32: pixel / tdata width.
- KERNEL_SIZE, 5: convolution kernel size. Output frame is cropped by KERNEL_SIZE-1 in each dimension.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of 2, ≥4.
- AF_MARGIN, 4: o_almost_full asserts when FIFO count ≥ FIFO_DEPTH-AF_MARGIN.

Ports:
- i_clk  in  1  clock
- i_aresetn  in  1  async reset, active-low
- WIDTH  in  13  input image width; held static during a frame
- HEIGHT  in  13  input image height; held static during a frame
- i_pixel  in  DATA_WIDTH  Gx/Gy vector
- i_pixel_valid  in  1  i_pixel valid this cycle
- i_start_of_frame  in  1  qualifies the first pixel of a frame; ignored unless i_pixel_valid=1
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tlast  out  1  last pixel of line
- m_axis_tready  in  1  downstream ready
- o_almost_full  out  1  FIFO level warning
- o_overflow  out  1  sticky: an accepted pixel was dropped
- o_frame_err  out  1  one-cycle pulse: SOF arrived mid-frame
- i_clear_status  in  1  synchronous clear of o_overflow

Behaviour:
- Reset (async, i_aresetn=0): all outputs 0, FIFO empty, counters 0, state IDLE.
- Geometry: OUT_W = WIDTH-(KERNEL_SIZE-1), OUT_H = HEIGHT-(KERNEL_SIZE-1). Both are 13-bit, registered at SOF. If WIDTH or HEIGHT < KERNEL_SIZE, the frame is treated as empty: pixels are dropped and o_frame_err pulses on SOF.
- Write-side FSM states: IDLE, IN_FRAME.
  - IDLE: valid pixels without SOF are discarded. Valid+SOF → IN_FRAME; col=0, row=0; that pixel is tagged tuser=1.
  - IN_FRAME: each valid pixel is tagged tuser=(col==0 && row==0), tlast=(col==OUT_W-1).
  - Counters: col wraps to 0 at OUT_W-1 and increments row. On the pixel where col==OUT_W-1 && row==OUT_H-1, go to IDLE.
  - Valid+SOF while in IN_FRAME: pulse o_frame_err, restart counters at this pixel (tag tuser=1), remain IN_FRAME.
- FIFO entry = {tuser, tlast, data}.
  - Write when a tagged pixel exists and the FIFO is not full.
  - If the FIFO is full: drop the pixel, set o_overflow=1. The frame counters still advance so framing stays aligned.
  - i_clear_status clears o_overflow. An overflow in the same cycle wins (flag stays 1).
- Output register:
  - Loads from the FIFO head when FIFO non-empty && (!m_axis_tvalid || m_axis_tready).
  - m_axis_tvalid=0 when the FIFO is empty and the current beat is consumed.
  - tdata/tuser/tlast are stable while tvalid && !tready.
- Latency: pixel valid at edge k → FIFO write at k → m_axis_tvalid=1 after edge k+1, given an empty path and tready=1.
- Throughput: 1 beat/cycle sustained with tready=1.
- Capacity: FIFO_DEPTH + 1 (output register).
- Simultaneous FIFO read and write when full: the write succeeds and no overflow is flagged.
- o_almost_full is combinational from the registered count.
- Reset mid-frame: immediate flush. tvalid drops asynchronously and the frame is lost.

Decomposition:
- Package gxgy_pkg:
  - typedef gxgy_beat_t = packed struct {tuser, tlast, data[31:0]}
  - constant IMG_DIM_W=13
- Sub-module gxgy_sync_fifo:
  - Parameterized by DATA type width and DEPTH.
  - Ports: wr_en, din, rd_en, dout, full, empty, count.
  - Show-ahead read.
- Write FSM, counters and output register live in the top module.

Test Plan:
- WIDTH=8, HEIGHT=7, continuous 12 pixels with SOF on the first, tready=1 → 4x3 output. tuser only on beat 0; tlast on beats 3, 7, 11. First tvalid 2 cycles after the first input. No gaps.
- Same frame, tready toggling 1-0-1-0 → all 12 beats in order; data/tuser/tlast held during stalls; o_overflow=0.
- tready=0 throughout, 20 continuous pixels (WIDTH=HEIGHT=24) → 17 retained, 3 dropped. o_overflow=1; o_almost_full asserts once the FIFO count reaches 12. Then raise i_clear_status → o_overflow=0.
- 5 valid pixels before any SOF, then a frame → the first 5 are discarded; output starts with the SOF pixel, tuser=1.
- SOF at pixel 6 of a 12-pixel frame → o_frame_err pulses 1 cycle; that beat has tuser=1; tlast follows at the restarted column 3.
- Assert i_aresetn=0 with 8 beats buffered → all outputs 0 immediately. After release, a new frame outputs correctly with no stale beats.
